dbi_encode_lanes: RTL and testbench
===================================

Name: dbi_encode_lanes

Overview:
- Parametrised, lane-split data bus inversion (DBI) encoder for wide systolic-array operand and result buses.
- Each LANE_W-bit lane gets its own DBI flag.
- Modes: AC (minimise toggles against the last transmitted word) or DC (minimise ones).
- Sits between the array edge buffers and the long interconnect; valid/ready on both sides, one register stage.

Parameters:
- BW, 128, total data width; must be a multiple of LANE_W.
- LANE_W, 8, lane width; one DBI bit per lane; must be even and at least 2.
- LANES, BW/LANE_W, derived lane count; not overridden.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high.
- dbi_en  input  1  1 = encode; 0 = pass-through (all DBI bits 0).
- dbi_mode  input  1  0 = AC (toggle-minimising); 1 = DC (ones-minimising). Sampled with each accepted beat.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  block can accept a beat.
- data_in  input  BW  raw data.
- out_valid  output  1  data_out/dbi_out valid.
- out_ready  input  1  downstream accepts.
- data_out  output  BW  encoded data (lane k possibly inverted).
- dbi_out  output  LANES  bit k = 1 means lane k of data_out is inverted.

Behaviour:
- Reset values:
  - out_valid=0, data_out=0, dbi_out=0.
  - prev_tx=0 (internal BW-bit last transmitted word).
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept occurs when in_valid && in_ready.
  - Latency: exactly 1 cycle from accept to out_valid.
- Holding output:
  - While out_valid && !out_ready, data_out, dbi_out and prev_tx hold stable.
  - data_in is ignored.
- Clearing output: when out_ready && out_valid and there is no new accept, out_valid falls to 0 and data_out holds its value.
- Per-lane decision on accept, lane k = bits [k*LANE_W +: LANE_W]:
  - AC mode: cnt = popcount(data_in lane XOR prev_tx lane).
  - DC mode: cnt = popcount(data_in lane).
  - Invert when cnt > LANE_W/2 (strictly greater). A tie (== LANE_W/2) does not invert.
  - cnt is ceil(log2(LANE_W+1)) bits wide, built as a lane-local adder tree. No accumulation across beats.
- On accept, registered outputs:
  - data_out lane = inv ? ~data_in lane : data_in lane.
  - dbi_out[k] = inv.
  - prev_tx <= the new data_out value, i.e. the transmitted pattern, inverted lanes included.
- dbi_en=0:
  - data_out = data_in and dbi_out = 0.
  - prev_tx is still updated to data_in, so the AC history stays correct when encoding resumes.
- Mode switching: a dbi_mode change applies from the next accepted beat. prev_tx is updated in DC mode too.
- Back-to-back accepts (out_ready held 1): one beat per cycle, each compared against the previous beat's transmitted value.
- Reset mid-operation: the in-flight beat is dropped, history clears to 0, and in_ready is 1 in the cycle after reset deasserts.

Optional Feature:
- DBI_STATS_EN defined:
  - Adds output port inv_count [31:0].
  - On each accept it adds popcount(dbi_out bits of that beat); saturates at 32'hFFFF_FFFF.
  - Cleared by reset.
  - Counts nothing when dbi_en=0.
- Not defined: port and counter are absent; all other behaviour is identical.

Test Plan (BW=16, LANE_W=8 unless noted):
- After reset, AC, dbi_en=1, out_ready=1, accept 16'hFFFF:
  - Next cycle: out_valid=1, data_out=16'h0000, dbi_out=2'b11.
  - prev_tx=0000.
- Follow-on AC beat 16'h0F0F: XOR popcount 4 per lane (tie) -> data_out=16'h0F0F, dbi_out=2'b00.
- DC mode, accept 16'hFE01:
  - Lane1: 7 ones, inverted to 8'h01. Lane0: 1 one, not inverted.
  - Result: data_out=16'h0101, dbi_out=2'b10.
- Backpressure: beat accepted, then out_ready=0 for 3 cycles with data_in toggling:
  - in_ready=0 throughout; data_out/dbi_out stable; prev_tx unchanged.
  - When out_ready returns to 1, the next beat is encoded against the held value.
- dbi_en=0 beat 16'hFFFF -> data_out=16'hFFFF, dbi_out=0. Then dbi_en=1 AC beat 16'hFFFF -> XOR 0, no inversion, dbi_out=0.
- Reset asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0, dbi_out=0. With DBI_STATS_EN defined, inv_count=0; after scenarios 1 and 3 it equals 3.

Source files
------------

// File: rtl/dbi_encode_lanes.sv
// Lane-split data bus inversion encoder with one valid/ready register stage.
// Optional inversion statistics counter when DBI_STATS_EN is defined.
module dbi_encode_lanes #(
  parameter  int BW     = 128,
  parameter  int LANE_W = 8,
  localparam int LANES  = BW / LANE_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dbi_en,
  input  logic             dbi_mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BW-1:0]    data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BW-1:0]    data_out,
  output logic [LANES-1:0] dbi_out
`ifdef DBI_STATS_EN
  ,
  output logic [31:0]      inv_count
`endif
);

  localparam int CNT_W = $clog2(LANE_W + 1);
  localparam int HALF  = LANE_W / 2;

  if (BW % LANE_W != 0) begin : g_bad_bw
    $error("BW must be a multiple of LANE_W");
  end
  if ((LANE_W < 2) || (LANE_W % 2 != 0)) begin : g_bad_lane_w
    $error("LANE_W must be even and at least 2");
  end

  function automatic logic [CNT_W-1:0] lane_popcount(input logic [LANE_W-1:0] v);
    logic [CNT_W-1:0] sum;
    sum = '0;
    for (int i = 0; i < LANE_W; i++) begin
      sum = sum + CNT_W'(v[i]);
    end
    return sum;
  endfunction

  logic             accept;
  logic [BW-1:0]    prev_tx;
  logic [BW-1:0]    cmp_word;
  logic [BW-1:0]    enc_word;
  logic [LANES-1:0] inv;
  logic [CNT_W-1:0] cnt [LANES];

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // The last transmitted word is exactly what data_out holds, so it doubles as the AC history.
  assign prev_tx  = data_out;

  assign cmp_word = dbi_mode ? data_in : (data_in ^ prev_tx);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign cnt[k] = lane_popcount(cmp_word[k*LANE_W +: LANE_W]);
    assign inv[k] = dbi_en && (cnt[k] > CNT_W'(HALF));
    assign enc_word[k*LANE_W +: LANE_W] = inv[k] ? ~data_in[k*LANE_W +: LANE_W]
                                                 :  data_in[k*LANE_W +: LANE_W];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      dbi_out   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      data_out  <= enc_word;
      dbi_out   <= inv;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef DBI_STATS_EN
  localparam int INV_W = $clog2(LANES + 1);

  logic [INV_W-1:0] inv_pop;
  logic [32:0]      inv_sum;

  always_comb begin
    inv_pop = '0;
    for (int i = 0; i < LANES; i++) begin
      inv_pop = inv_pop + INV_W'(inv[i]);
    end
  end

  assign inv_sum = {1'b0, inv_count} + 33'(inv_pop);

  // inv is forced low when dbi_en=0, so pass-through beats add nothing.
  always_ff @(posedge clk) begin
    if (reset) begin
      inv_count <= '0;
    end else if (accept) begin
      inv_count <= inv_sum[32] ? 32'hFFFF_FFFF : inv_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_dbi_encode_lanes.sv
// Self-checking bench for dbi_encode_lanes (BW=16, LANE_W=8): vector table,
// hand-written handshake/reset sequences and a short random run, all via a scoreboard.
module tb_dbi_encode_lanes;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  dbi;
  } exp_t;

  typedef struct {
    logic        en;
    logic        mode;
    logic [15:0] din;
    logic [15:0] dout;
    logic [1:0]  dbi;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dbi_en = 1'b1;
  logic        dbi_mode = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] data_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] data_out;
  logic [1:0]  dbi_out;
`ifdef DBI_STATS_EN
  logic [31:0] inv_count;
`endif

  int   n_vec = 0;
  int   n_bad = 0;
  exp_t sb[$];
  logic [15:0] model_prev = '0;
  vec_t tbl [12];

  dbi_encode_lanes #(.BW(16), .LANE_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .dbi_en    (dbi_en),
    .dbi_mode  (dbi_mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .dbi_out   (dbi_out)
`ifdef DBI_STATS_EN
    ,
    .inv_count (inv_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic en, input logic mode,
                                 input logic [15:0] d, input logic [15:0] prev);
    exp_t        e;
    logic [7:0]  lane;
    logic [7:0]  cmp;
    for (int k = 0; k < 2; k++) begin
      lane = d[k*8 +: 8];
      cmp  = mode ? lane : (lane ^ prev[k*8 +: 8]);
      e.dbi[k] = en && ($countones(cmp) > 4);
      e.data[k*8 +: 8] = e.dbi[k] ? ~lane : lane;
    end
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the beat was taken.
  task automatic send(input logic en, input logic mode, input logic [15:0] d,
                      input exp_t e, input bit rnd_ready);
    bit ok;
    ok       = 1'b0;
    dbi_en   = en;
    dbi_mode = mode;
    data_in  = d;
    in_valid = 1'b1;
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        model_prev = e.data;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
      if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
    if (!ok) begin
      n_vec++;
      n_bad++;
      $display("FAIL accept_timeout: in_ready stayed 0, required 1 within 50 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int cycles);
    in_valid = 1'b0;
    repeat (cycles) begin
      @(posedge clk); #1;
    end
  endtask

  // Output monitor: every completed output handshake is matched against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_beat", 32'(out_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("data_out", 32'(data_out), 32'(e.data));
        check("dbi_out", 32'(dbi_out), 32'(e.dbi));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic        r_en;
    logic        r_mode;
    logic [15:0] r_d;

    tbl[0]  = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 2'b11};
    tbl[1]  = '{1'b1, 1'b0, 16'h0F0F, 16'h0F0F, 2'b00};
    tbl[2]  = '{1'b1, 1'b1, 16'hFE01, 16'h0101, 2'b10};
    tbl[3]  = '{1'b1, 1'b0, 16'h0101, 16'h0101, 2'b00};
    tbl[4]  = '{1'b1, 1'b0, 16'hFEFE, 16'h0101, 2'b11};
    tbl[5]  = '{1'b1, 1'b0, 16'h1F01, 16'h1F01, 2'b00};
    tbl[6]  = '{1'b1, 1'b1, 16'h1F3F, 16'hE0C0, 2'b11};
    tbl[7]  = '{1'b1, 1'b1, 16'h0F70, 16'h0F70, 2'b00};
    tbl[8]  = '{1'b1, 1'b0, 16'hF08F, 16'h0F70, 2'b11};
    tbl[9]  = '{1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 2'b00};
    tbl[10] = '{1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 2'b00};
    tbl[11] = '{1'b1, 1'b0, 16'h0000, 16'hFFFF, 2'b11};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_dbi_out", 32'(dbi_out), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef DBI_STATS_EN
    check("rst_inv_count", inv_count, 32'd0);
`endif
    @(posedge clk); #1;

    // Back-to-back table beats with out_ready held high.
    for (int i = 0; i < 12; i++) begin
      send(tbl[i].en, tbl[i].mode, tbl[i].din, '{data: tbl[i].dout, dbi: tbl[i].dbi}, 1'b0);
`ifdef DBI_STATS_EN
      if (i == 2) check("inv_count_after_3", inv_count, 32'd3);
`endif
    end

    // Output consumed with no new accept: valid drops, data holds.
    idle(2);
    @(negedge clk);
    check("clear_out_valid", 32'(out_valid), 32'd0);
    check("clear_data_hold", 32'(data_out), 32'hFFFF);
    @(posedge clk); #1;

    // Backpressure: held beat must not move while data_in toggles.
    out_ready = 1'b0;
    send(1'b1, 1'b0, 16'h00FF, '{data: 16'hFFFF, dbi: 2'b10}, 1'b0);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      dbi_mode = i[0];
      data_in  = i[0] ? 16'h5A5A : 16'hA5A5;
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_data_hold", 32'(data_out), 32'hFFFF);
      check("bp_dbi_hold", 32'(dbi_out), 32'h2);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(1'b1, 1'b0, 16'h01FE, '{data: 16'hFEFE, dbi: 2'b10}, 1'b0);
    idle(2);

    // Reset while a beat is held under backpressure.
    out_ready = 1'b0;
    send(1'b1, 1'b1, 16'h3C3C, '{data: 16'h3C3C, dbi: 2'b00}, 1'b0);
    @(negedge clk);
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    sb.delete();
    model_prev = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_dbi_out", 32'(dbi_out), 32'h0);
    check("mid_rst_data_out", 32'(data_out), 32'h0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
`ifdef DBI_STATS_EN
    check("mid_rst_inv_count", inv_count, 32'd0);
`endif
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(1'b1, 1'b0, 16'hFFFF, '{data: 16'h0000, dbi: 2'b11}, 1'b0);

    // Random beats against the reference model with random downstream stalls.
    for (int i = 0; i < 24; i++) begin
      r_en   = ($urandom_range(0, 4) != 0);
      r_mode = 1'($urandom_range(0, 1));
      r_d    = 16'($urandom);
      e      = model(r_en, r_mode, r_d, model_prev);
      send(r_en, r_mode, r_d, e, 1'b1);
    end

    out_ready = 1'b1;
    idle(4);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
